result_writeback: RTL and testbench



---
 rtl/sc_pkg.sv | 17 +
 rtl/result_fifo.sv | 71 +++++++
 rtl/result_writeback.sv | 100 ++++++++++
 tb/tb_result_writeback.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared constants and helpers for the SC PE-cube result write-back path.
package sc_pkg;

    localparam int RESULT_W       = 8;
    localparam int RESULT_NUM     = 27;
    localparam int WORDS_PER_SET  = 7;
    localparam int BYTES_PER_WORD = 4;
    localparam int SEL_W          = 3;
    localparam int IDX_W          = 5;

    // Byte j of output word sel comes from FIFO 4*sel+j.
    function automatic logic [IDX_W-1:0] fifoIndex(input logic [SEL_W-1:0] sel,
                                                   input logic [1:0]       j);
        return {sel, j};
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO with registered read; dout holds until the next pop and
// an underflowing pop returns zero.
module result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q, rdPtr_q;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] dout_q;
    logic             doPush, doPop;

    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == (AW+1)'(DEPTH));
    assign doPop       = pop_i & ~empty_o;
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign doPush      = push_i & (~full_o | pop_i);
    assign overflow_o  = push_i & full_o & ~pop_i;
    assign underflow_o = pop_i & empty_o;
    assign dout_o      = dout_q;

    always_comb begin
        count_d = count_q;
        case ({doPush, doPop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            count_q <= count_d;
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            if (pop_i) begin
                dout_q <= doPop ? mem_q[rdPtr_q] : '0;
            end
        end
    end

endmodule

// File: rtl/result_writeback.sv
// Buffers per-PE results in FIFOs and packs four results per 32-bit word
// onto the output RAM write port under controller sequencing.
module result_writeback
    import sc_pkg::*;
#(
    parameter int RESULT_NUM = sc_pkg::RESULT_NUM,
    parameter int RESULT_W   = sc_pkg::RESULT_W,
    parameter int FIFO_DEPTH = 4,
    parameter int RAM_DEPTH  = 2048
) (
    input  logic                           iClk,
    input  logic                           iRst,
    input  logic [RESULT_NUM-1:0]          iResultValid,
    input  logic [RESULT_NUM*RESULT_W-1:0] iResult,
    output logic                           oAllResultFifoHasData,
    input  logic [RESULT_NUM-1:0]          iResultRdEn,
    input  logic                           iWriteEn,
    input  logic [$clog2(RAM_DEPTH)-1:0]   iAddrWr,
    input  logic [SEL_W-1:0]               iResultFifoSel,
    output logic                           oRamWe,
    output logic [$clog2(RAM_DEPTH)-1:0]   oRamAddr,
    output logic [31:0]                    oRamWData,
    output logic                           oOverflow,
    output logic                           oUnderflow
);

    localparam int AW      = $clog2(RAM_DEPTH);
    localparam int PAD_NUM = (1 << SEL_W) * BYTES_PER_WORD;

    logic [RESULT_NUM-1:0] fifoFull, fifoEmpty, fifoOvf, fifoUnf;
    logic [RESULT_W-1:0]   fifoDout   [RESULT_NUM];
    logic [RESULT_W-1:0]   paddedDout [PAD_NUM];
    logic                  unusedFull;

    logic          ramWe_q;
    logic [AW-1:0] ramAddr_q;
    logic [31:0]   ramWData_q, ramWData_d;
    logic          overflow_q, overflow_d, underflow_q, underflow_d;

    for (genvar n = 0; n < RESULT_NUM; n++) begin : gFifo
        result_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(RESULT_W)) uFifo (
            .clk         (iClk),
            .rst         (iRst),
            .push_i      (iResultValid[n]),
            .din_i       (iResult[n*RESULT_W +: RESULT_W]),
            .pop_i       (iResultRdEn[n]),
            .dout_o      (fifoDout[n]),
            .full_o      (fifoFull[n]),
            .empty_o     (fifoEmpty[n]),
            .overflow_o  (fifoOvf[n]),
            .underflow_o (fifoUnf[n])
        );
    end

    // Indices past the last PE read as zero so sel 6 and 7 pad cleanly.
    for (genvar p = 0; p < PAD_NUM; p++) begin : gPad
        if (p < RESULT_NUM) begin : gReal
            assign paddedDout[p] = fifoDout[p];
        end else begin : gZero
            assign paddedDout[p] = '0;
        end
    end

    assign unusedFull            = ^fifoFull;
    assign oAllResultFifoHasData = &(~fifoEmpty);

    always_comb begin
        ramWData_d = '0;
        for (int j = 0; j < BYTES_PER_WORD; j++) begin
            ramWData_d[j*RESULT_W +: RESULT_W] = paddedDout[fifoIndex(iResultFifoSel, 2'(j))];
        end
        overflow_d  = overflow_q  | (|fifoOvf);
        underflow_d = underflow_q | (|fifoUnf);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            ramWe_q     <= 1'b0;
            ramAddr_q   <= '0;
            ramWData_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            ramWe_q     <= iWriteEn;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            if (iWriteEn) begin
                ramAddr_q  <= iAddrWr;
                ramWData_q <= ramWData_d;
            end
        end
    end

    assign oRamWe     = ramWe_q;
    assign oRamAddr   = ramAddr_q;
    assign oRamWData  = ramWData_q;
    assign oOverflow  = overflow_q;
    assign oUnderflow = underflow_q;

endmodule

// File: tb/tb_result_writeback.sv
// Self-checking bench for result_writeback: vector table for the packed set,
// scoreboard of expected RAM writes, hand sequences for FIFO corner cases.
module tb_result_writeback;

    localparam int N  = 27;
    localparam int W  = 8;
    localparam int AW = 11;

    logic              iClk = 1'b0;
    logic              iRst;
    logic [N-1:0]      iResultValid;
    logic [N*W-1:0]    iResult;
    logic              oAllResultFifoHasData;
    logic [N-1:0]      iResultRdEn;
    logic              iWriteEn;
    logic [AW-1:0]     iAddrWr;
    logic [2:0]        iResultFifoSel;
    logic              oRamWe;
    logic [AW-1:0]     oRamAddr;
    logic [31:0]       oRamWData;
    logic              oOverflow;
    logic              oUnderflow;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    typedef struct {
        logic [2:0]    sel;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } vec_t;

    wr_t  expQ [$];
    vec_t vecs [8];
    int   total = 0;
    int   bad   = 0;

    always #5 iClk = ~iClk;

    result_writeback #(.RESULT_NUM(N), .RESULT_W(W), .FIFO_DEPTH(4), .RAM_DEPTH(2048)) dut (
        .iClk                  (iClk),
        .iRst                  (iRst),
        .iResultValid          (iResultValid),
        .iResult               (iResult),
        .oAllResultFifoHasData (oAllResultFifoHasData),
        .iResultRdEn           (iResultRdEn),
        .iWriteEn              (iWriteEn),
        .iAddrWr               (iAddrWr),
        .iResultFifoSel        (iResultFifoSel),
        .oRamWe                (oRamWe),
        .oRamAddr              (oRamAddr),
        .oRamWData             (oRamWData),
        .oOverflow             (oOverflow),
        .oUnderflow            (oUnderflow)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Every RAM write pulse is matched against the oldest expected write.
    always @(negedge iClk) begin : monitor
        wr_t e;
        if (oRamWe === 1'b1) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected write: got addr 0x%03h data 0x%08h want no write",
                         oRamAddr, oRamWData);
            end else begin
                e = expQ.pop_front();
                checkOutput("ram addr", 32'(oRamAddr), 32'(e.addr));
                checkOutput("ram data", oRamWData, e.data);
            end
        end
    end

    function automatic logic [N-1:0] bitOf(input int n);
        logic [N-1:0] m;
        m    = '0;
        m[n] = 1'b1;
        return m;
    endfunction

    function automatic logic [N-1:0] groupMask(input int k);
        logic [N-1:0] m;
        m = '0;
        for (int j = 0; j < 4; j++) begin
            if (4*k + j < N) m[4*k + j] = 1'b1;
        end
        return m;
    endfunction

    task automatic setResult(input int n, input logic [7:0] v);
        iResult[n*W +: W] = v;
    endtask

    task automatic applyStimulus(input logic [N-1:0] valid, input logic [N-1:0] rd,
                                 input logic we, input logic [2:0] sel, input logic [AW-1:0] addr);
        iResultValid   = valid;
        iResultRdEn    = rd;
        iWriteEn       = we;
        iResultFifoSel = sel;
        iAddrWr        = addr;
        @(posedge iClk);
        #1;
    endtask

    task automatic idle();
        applyStimulus('0, '0, 1'b0, 3'd0, '0);
    endtask

    task automatic popWrite(input logic [N-1:0] mask, input logic [2:0] sel,
                            input logic [AW-1:0] addr, input logic [31:0] data);
        applyStimulus('0, mask, 1'b0, 3'd0, '0);
        expQ.push_back('{addr: addr, data: data});
        applyStimulus('0, '0, 1'b1, sel, addr);
        idle();
    endtask

    task automatic doReset();
        iRst = 1'b1;
        applyStimulus('0, '0, 1'b0, 3'd0, '0);
        applyStimulus('0, '0, 1'b0, 3'd0, '0);
        iRst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{3'd0, 11'd0,  32'h04030201};
        vecs[1] = '{3'd1, 11'd4,  32'h08070605};
        vecs[2] = '{3'd2, 11'd8,  32'h0C0B0A09};
        vecs[3] = '{3'd3, 11'd12, 32'h100F0E0D};
        vecs[4] = '{3'd4, 11'd16, 32'h14131211};
        vecs[5] = '{3'd5, 11'd20, 32'h18171615};
        vecs[6] = '{3'd6, 11'd24, 32'h001B1A19};
        vecs[7] = '{3'd7, 11'd28, 32'h00000000};

        iResult = '0;
        doReset();
        checkOutput("reset we",        oRamWe, 0);
        checkOutput("reset addr",      32'(oRamAddr), 0);
        checkOutput("reset data",      oRamWData, 0);
        checkOutput("reset overflow",  oOverflow, 0);
        checkOutput("reset underflow", oUnderflow, 0);
        checkOutput("reset all-data",  oAllResultFifoHasData, 0);

        // Fill every FIFO with PE index + 1 in a single cycle.
        for (int n = 0; n < N; n++) setResult(n, 8'(n + 1));
        applyStimulus('1, '0, 1'b0, 3'd0, '0);
        checkOutput("all-data after fill", oAllResultFifoHasData, 1);
        idle();

        for (int k = 0; k < 8; k++) begin
            applyStimulus('0, groupMask(int'(vecs[k].sel)), 1'b0, 3'd0, '0);
            if (k == 0) checkOutput("all-data after group0 pop", oAllResultFifoHasData, 0);
            expQ.push_back('{addr: vecs[k].addr, data: vecs[k].data});
            applyStimulus('0, '0, 1'b1, vecs[k].sel, vecs[k].addr);
            checkOutput("we pulse", oRamWe, 1);
            idle();
            checkOutput("we drops", oRamWe, 0);
        end
        checkOutput("set overflow",  oOverflow, 0);
        checkOutput("set underflow", oUnderflow, 0);

        // FIFO 0 overflow: fifth push is dropped, first four drain in order.
        doReset();
        for (int i = 1; i <= 5; i++) begin
            setResult(0, 8'(i));
            applyStimulus(bitOf(0), '0, 1'b0, 3'd0, '0);
            if (i == 4) checkOutput("overflow before 5th", oOverflow, 0);
        end
        idle();
        checkOutput("overflow after 5th", oOverflow, 1);
        for (int i = 1; i <= 4; i++) popWrite(bitOf(0), 3'd0, 11'(4*i), 32'(i));
        checkOutput("no underflow draining", oUnderflow, 0);

        // FIFO 3: one real pop then an empty pop, seen through byte 3 of sel 0.
        setResult(3, 8'h77);
        applyStimulus(bitOf(3), '0, 1'b0, 3'd0, '0);
        idle();
        popWrite(bitOf(3), 3'd0, 11'h40, 32'h77000004);
        checkOutput("underflow before empty pop", oUnderflow, 0);
        popWrite(bitOf(3), 3'd0, 11'h44, 32'h00000004);
        checkOutput("underflow after empty pop", oUnderflow, 1);

        // FIFO 5 full with a simultaneous push and pop.
        doReset();
        for (int i = 0; i < 4; i++) begin
            setResult(5, 8'(8'h51 + i));
            applyStimulus(bitOf(5), '0, 1'b0, 3'd0, '0);
        end
        setResult(5, 8'hAA);
        applyStimulus(bitOf(5), bitOf(5), 1'b0, 3'd0, '0);
        expQ.push_back('{addr: 11'h80, data: 32'h00005100});
        applyStimulus('0, '0, 1'b1, 3'd1, 11'h80);
        idle();
        checkOutput("no overflow on push+pop", oOverflow, 0);
        popWrite(bitOf(5), 3'd1, 11'h84, 32'h00005200);
        popWrite(bitOf(5), 3'd1, 11'h88, 32'h00005300);
        popWrite(bitOf(5), 3'd1, 11'h8C, 32'h00005400);
        popWrite(bitOf(5), 3'd1, 11'h90, 32'h0000AA00);
        checkOutput("count stayed 4", oUnderflow, 0);
        applyStimulus('0, bitOf(5), 1'b0, 3'd0, '0);
        idle();
        checkOutput("fifo5 empty after 5 pops", oUnderflow, 1);

        // Reset arriving right after a sel 2 write, with another write in flight.
        for (int n = 0; n < N; n++) setResult(n, 8'(n + 1));
        applyStimulus('1, '0, 1'b0, 3'd0, '0);
        for (int i = 0; i < 4; i++) begin
            setResult(0, 8'(8'h21 + i));
            applyStimulus(bitOf(0), '0, 1'b0, 3'd0, '0);
        end
        idle();
        checkOutput("pre-reset overflow",  oOverflow, 1);
        checkOutput("pre-reset underflow", oUnderflow, 1);
        checkOutput("pre-reset all-data",  oAllResultFifoHasData, 1);
        applyStimulus('0, groupMask(2), 1'b0, 3'd0, '0);
        expQ.push_back('{addr: 11'd8, data: 32'h0C0B0A09});
        applyStimulus('0, '0, 1'b1, 3'd2, 11'd8);
        iRst = 1'b1;
        applyStimulus('1, groupMask(3), 1'b1, 3'd3, 11'd12);
        checkOutput("mid-burst we",        oRamWe, 0);
        checkOutput("mid-burst addr",      32'(oRamAddr), 0);
        checkOutput("mid-burst data",      oRamWData, 0);
        checkOutput("mid-burst overflow",  oOverflow, 0);
        checkOutput("mid-burst underflow", oUnderflow, 0);
        checkOutput("mid-burst all-data",  oAllResultFifoHasData, 0);
        iRst = 1'b0;
        idle();
        idle();

        checkOutput("pending writes", 32'(expQ.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
